// File: rtl/mst_mch_fifo_ctl.sv
// Multi-channel FIFO controller with an inferred single-clock RAM shared by all channels.
// In 245 mode (mltcn=0) the whole RAM is pooled into channel 0.
module mst_mch_fifo_ctl #(
    parameter int NCH       = 4,
    parameter int DW        = 36,
    parameter int AW        = 12,
    parameter int AF_MARGIN = 4,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TAW      = AW + CW,
    localparam int LW       = TAW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mltcn,
    input  logic              wr,
    input  logic [CW-1:0]     wrid,
    input  logic [DW-1:0]     wdat,
    input  logic              rd,
    input  logic [CW-1:0]     rdid,
    output logic [DW-1:0]     rdat,
    output logic              rvld,
    input  logic [NCH-1:0]    flush,
    input  logic              err_clr,
    output logic [NCH-1:0]    nempt,
    output logic [NCH-1:0]    full,
    output logic [NCH-1:0]    afull,
    output logic [NCH*LW-1:0] level,
    output logic [NCH-1:0]    ovf,
    output logic [NCH-1:0]    udf
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]  mem [1 << TAW];
    logic [LW-1:0]  wptr_q  [NCH];
    logic [LW-1:0]  rptr_q  [NCH];
    logic [LW-1:0]  wptr_nx [NCH];
    logic [LW-1:0]  rptr_nx [NCH];
    logic [LW-1:0]  lvl_q   [NCH];
    logic [LW-1:0]  lvl_nx  [NCH];
    logic [NCH-1:0] nempt_nx, full_nx, afull_nx, ovf_set, udf_set;
    logic           mltcn_q, mode_chg;
    logic [CW-1:0]  wc, rc;
    logic           same_ch, wr_try, rd_try, wr_acc, rd_acc;
    logic [TAW-1:0] waddr, raddr;
    logic [LW-1:0]  cap;

    // Handshake: rd is a strobe with no back-pressure; it is accepted only when the
    // registered nempt of its channel is set, and then rvld/rdat follow exactly one cycle later.
    always_comb begin
        mode_chg = mltcn ^ mltcn_q;
        wc       = mltcn ? wrid : '0;
        rc       = mltcn ? rdid : '0;
        cap      = mltcn ? LW'(DEPTH) : LW'(NCH * DEPTH);
        same_ch  = (wc == rc);
        rd_try   = rd & ~flush[rc] & ~mode_chg;
        wr_try   = wr & ~flush[wc] & ~mode_chg;
        rd_acc   = rd_try & nempt[rc];
        // A full channel still takes a write when the same channel is read this cycle.
        wr_acc   = wr_try & (~full[wc] | (rd_acc & same_ch));
        ovf_set  = '0;
        udf_set  = '0;
        if (wr_try && !wr_acc) ovf_set[wc] = 1'b1;
        if (rd_try && !rd_acc) udf_set[rc] = 1'b1;
        waddr    = mltcn ? {wc, wptr_q[wc][AW-1:0]} : wptr_q[0][TAW-1:0];
        raddr    = mltcn ? {rc, rptr_q[rc][AW-1:0]} : rptr_q[0][TAW-1:0];
        for (int c = 0; c < NCH; c++) begin
            wptr_nx[c] = wptr_q[c];
            rptr_nx[c] = rptr_q[c];
            if (wr_acc && wc == CW'(c)) wptr_nx[c] = wptr_q[c] + 1'b1;
            if (rd_acc && rc == CW'(c)) rptr_nx[c] = rptr_q[c] + 1'b1;
            if (flush[c]) rptr_nx[c] = wptr_q[c];
            if (mode_chg) begin
                wptr_nx[c] = '0;
                rptr_nx[c] = '0;
            end
            lvl_nx[c]   = wptr_nx[c] - rptr_nx[c];
            nempt_nx[c] = (lvl_nx[c] != '0);
            full_nx[c]  = (lvl_nx[c] == cap);
            afull_nx[c] = ((cap - lvl_nx[c]) <= LW'(AF_MARGIN));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[waddr] <= wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mltcn_q <= 1'b1;
            rdat    <= '0;
            rvld    <= 1'b0;
            nempt   <= '0;
            full    <= '0;
            afull   <= '0;
            ovf     <= '0;
            udf     <= '0;
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                lvl_q[c]  <= '0;
            end
        end else begin
            mltcn_q <= mltcn;
            rvld    <= rd_acc;
            if (rd_acc) rdat <= mem[raddr];
            nempt   <= nempt_nx;
            full    <= full_nx;
            afull   <= afull_nx;
            // A same-cycle error event beats err_clr.
            ovf     <= (ovf & ~{NCH{err_clr}}) | ovf_set;
            udf     <= (udf & ~{NCH{err_clr}}) | udf_set;
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c] <= wptr_nx[c];
                rptr_q[c] <= rptr_nx[c];
                lvl_q[c]  <= lvl_nx[c];
            end
        end
    end

    always_comb begin
        level = '0;
        for (int c = 0; c < NCH; c++) level[c*LW +: LW] = lvl_q[c];
    end

endmodule

// File: tb/tb_mst_mch_fifo_ctl.sv
// Directed bench for mst_mch_fifo_ctl with NCH=4, AW=4 (16 entries/channel, 64 pooled).
module tb_mst_mch_fifo_ctl;

    localparam int NCH = 4;
    localparam int DW  = 36;
    localparam int AW  = 4;
    localparam int CW  = 2;
    localparam int LW  = 7;

    logic              clk;
    logic              rst_n;
    logic              mltcn;
    logic              wr;
    logic [CW-1:0]     wrid;
    logic [DW-1:0]     wdat;
    logic              rd;
    logic [CW-1:0]     rdid;
    logic [DW-1:0]     rdat;
    logic              rvld;
    logic [NCH-1:0]    flush;
    logic              err_clr;
    logic [NCH-1:0]    nempt;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    afull;
    logic [NCH*LW-1:0] level;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    udf;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    mst_mch_fifo_ctl #(.NCH(NCH), .DW(DW), .AW(AW), .AF_MARGIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .mltcn(mltcn),
        .wr(wr), .wrid(wrid), .wdat(wdat),
        .rd(rd), .rdid(rdid), .rdat(rdat), .rvld(rvld),
        .flush(flush), .err_clr(err_clr),
        .nempt(nempt), .full(full), .afull(afull), .level(level),
        .ovf(ovf), .udf(udf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl(input int c);
        return level[c*LW +: LW];
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; flush = '0; err_clr = 1'b0;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        wr = 1'b1; wrid = CW'(ch); wdat = d;
        cyc();
        wr = 1'b0;
    endtask

    task automatic pop_chk(input int ch, input string tag);
        logic [DW-1:0] e;
        rd = 1'b1; rdid = CW'(ch);
        cyc();
        rd = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_rvld"}, 64'(rvld), 64'd1);
        check({tag, "_rdat"}, 64'(rdat), 64'(e));
    endtask

    initial begin
        rst_n = 1'b0; mltcn = 1'b1; wrid = '0; rdid = '0; wdat = '0;
        idle();
        cyc(); cyc();
        check("rst_nempt", 64'(nempt), 64'd0);
        check("rst_full",  64'(full),  64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_rvld",  64'(rvld),  64'd0);
        check("rst_rdat",  64'(rdat),  64'd0);
        check("rst_err",   64'({ovf, udf}), 64'd0);
        rst_n = 1'b1;
        cyc(); cyc();

        // basic write/read on channel 2
        push(2, 36'hA); exp_q.push_back(36'hA);
        push(2, 36'hB); exp_q.push_back(36'hB);
        push(2, 36'hC); exp_q.push_back(36'hC);
        check("t1_level2", 64'(lvl(2)), 64'd3);
        check("t1_nempt",  64'(nempt), 64'b0100);
        pop_chk(2, "t1_rd0");
        pop_chk(2, "t1_rd1");
        pop_chk(2, "t1_rd2");
        cyc();
        check("t1_rvld_off", 64'(rvld), 64'd0);
        check("t1_rdat_hold", 64'(rdat), 64'hC);
        check("t1_nempt_end", 64'(nempt), 64'd0);

        // fill channel 1, almost-full threshold, overflow, read+write while full
        for (int i = 0; i < 16; i++) begin
            push(1, 36'h100 + 36'(i));
            exp_q.push_back(36'h100 + 36'(i));
            if (i == 10) check("t2_afull_l11", 64'(afull[1]), 64'd0);
            if (i == 11) check("t2_afull_l12", 64'(afull[1]), 64'd1);
            if (i == 14) check("t2_full_l15",  64'(full[1]),  64'd0);
        end
        check("t2_full", 64'(full), 64'b0010);
        check("t2_level1", 64'(lvl(1)), 64'd16);
        push(1, 36'hDEAD);
        check("t2_ovf", 64'(ovf), 64'b0010);
        check("t2_level_drop", 64'(lvl(1)), 64'd16);
        wr = 1'b1; wrid = 2'd1; wdat = 36'h1FF; exp_q.push_back(36'h1FF);
        pop_chk(1, "t2_rw_full");
        wr = 1'b0;
        check("t2_level_rw", 64'(lvl(1)), 64'd16);
        check("t2_ovf_rw", 64'(ovf), 64'b0010);
        for (int i = 0; i < 16; i++) pop_chk(1, "t2_drain");
        cyc();
        check("t2_nempt_end", 64'(nempt), 64'd0);

        // underflow and err_clr priority
        rd = 1'b1; rdid = 2'd3;
        cyc();
        rd = 1'b0;
        check("t3_udf", 64'(udf), 64'b1000);
        check("t3_rvld", 64'(rvld), 64'd0);
        err_clr = 1'b1;
        cyc();
        check("t3_udf_clr", 64'(udf), 64'd0);
        check("t3_ovf_clr", 64'(ovf), 64'd0);
        rd = 1'b1; rdid = 2'd3;
        cyc();
        idle();
        check("t3_udf_wins", 64'(udf), 64'b1000);

        // 245 mode: everything pools into channel 0
        mltcn = 1'b0;
        cyc();
        for (int i = 0; i < 64; i++) begin
            push(3, 36'h200 + 36'(i));
            exp_q.push_back(36'h200 + 36'(i));
        end
        check("t4_level0", 64'(lvl(0)), 64'd64);
        check("t4_level3", 64'(lvl(3)), 64'd0);
        check("t4_full", 64'(full), 64'b0001);
        check("t4_afull0", 64'(afull[0]), 64'd1);
        check("t4_nempt", 64'(nempt), 64'b0001);
        for (int i = 0; i < 64; i++) pop_chk(3, "t4_rd");
        cyc();
        check("t4_nempt_end", 64'(nempt), 64'd0);

        // flush with concurrent write
        mltcn = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) push(0, 36'h300 + 36'(i));
        push(2, 36'h31); push(2, 36'h32);
        check("t5_level0_pre", 64'(lvl(0)), 64'd5);
        flush = 4'b0001; wr = 1'b1; wrid = 2'd0; wdat = 36'h3FF;
        cyc();
        idle();
        check("t5_level0", 64'(lvl(0)), 64'd0);
        check("t5_ovf", 64'(ovf), 64'd0);
        check("t5_level2", 64'(lvl(2)), 64'd2);
        check("t5_nempt", 64'(nempt), 64'b0100);

        // mode toggle clears everything, then async reset mid-burst
        for (int i = 0; i < 3; i++) push(1, 36'h400 + 36'(i));
        mltcn = 1'b0;
        cyc();
        check("t6_mode_level", 64'(level), 64'd0);
        check("t6_mode_nempt", 64'(nempt), 64'd0);
        mltcn = 1'b1;
        cyc();
        push(0, 36'h5A); push(0, 36'h5B);
        rd = 1'b1; rdid = 2'd0; wr = 1'b1; wrid = 2'd0; wdat = 36'h5C;
        cyc();
        check("t6_pre_rvld", 64'(rvld), 64'd1);
        check("t6_pre_rdat", 64'(rdat), 64'h5A);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_rvld", 64'(rvld), 64'd0);
        check("t6_rst_rdat", 64'(rdat), 64'd0);
        check("t6_rst_nempt", 64'(nempt), 64'd0);
        check("t6_rst_level", 64'(level), 64'd0);
        check("t6_rst_err", 64'({ovf, udf}), 64'd0);
        idle();
        #20 rst_n = 1'b1;
        cyc();

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
